// File: rtl/store_align_pkg.sv
// Shared types for the store aligner: bus word, byte-enable mask and store width.
package store_align_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  byte_enable_t;

    typedef enum logic [1:0] {
        store_byte     = 2'd0,
        store_halfword = 2'd1,
        store_word     = 2'd2
    } store_mode_t;

    // An access needs a second beat when it runs past the last lane of its word.
    function automatic logic needs_split(input store_mode_t mode, input logic [1:0] bsel);
        return ((mode == store_halfword) && (bsel == 2'b11)) ||
               ((mode == store_word) && (bsel != 2'b00));
    endfunction

endpackage

// File: rtl/store_align_lane_gen.sv
// Combinational lane steering for stores: replicate by width, rotate into the
// big-endian lanes, and produce byte enables for the first and second beat.
module store_align_lane_gen
    import store_align_pkg::*;
(
    input  word_t        data,
    input  store_mode_t  mode,
    input  logic [1:0]   bsel,
    output word_t        lane_data,
    output byte_enable_t be_first,
    output byte_enable_t be_second
);

    word_t rep;

    // Replicate the right-aligned store data across the word.
    always_comb begin
        case (mode)
            store_byte:     rep = {4{data[7:0]}};
            store_halfword: rep = {2{data[15:0]}};
            default:        rep = data;
        endcase
    end

    // Rotate right by one lane per byte of offset; bsel 0 addresses bits 31:24.
    always_comb begin
        case (bsel)
            2'd0:    lane_data = rep;
            2'd1:    lane_data = {rep[7:0],  rep[31:8]};
            2'd2:    lane_data = {rep[15:0], rep[31:16]};
            default: lane_data = {rep[23:0], rep[31:24]};
        endcase
    end

    // First-beat enables, and the spill-over lanes of the next word.
    always_comb begin
        be_first  = 4'b0000;
        be_second = 4'b0000;
        case (mode)
            store_byte: begin
                be_first = 4'b1000 >> bsel;
            end
            store_halfword: begin
                be_first = 4'b1100 >> bsel;
                if (bsel == 2'b11) be_second = 4'b1000;
            end
            default: begin
                be_first  = 4'b1111 >> bsel;
                be_second = ~be_first;
            end
        endcase
    end

endmodule

// File: rtl/store_align.sv
// Store aligner between the load/store stage and the data-memory port.
// Build option STORE_ALIGN_MISALIGNED_EN: when defined, misaligned halfword and
// word stores are split into two bus beats; otherwise they are accepted, issue
// no beat, and pulse align_err.
module store_align
    import store_align_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  word_t        req_data,
    input  store_mode_t  req_mode,
    output logic         bus_en,
    input  logic         bus_ack,
    output logic [29:0]  bus_addr,
    output word_t        bus_data,
    output byte_enable_t bus_be,
    output logic         done,
    output logic         align_err
);

`ifdef STORE_ALIGN_MISALIGNED_EN
    typedef enum logic [1:0] {st_idle, st_beat1, st_beat2} state_t;
`else
    typedef enum logic [1:0] {st_idle, st_beat1} state_t;
`endif

    state_t       state;
    word_t        lane_data;
    byte_enable_t be_first;
    byte_enable_t be_second;
    logic         split;

    store_align_lane_gen u_lane_gen (
        .data      (req_data),
        .mode      (req_mode),
        .bsel      (req_addr[1:0]),
        .lane_data (lane_data),
        .be_first  (be_first),
        .be_second (be_second)
    );

    assign split     = needs_split(req_mode, req_addr[1:0]);
    assign req_ready = (state == st_idle);

`ifdef STORE_ALIGN_MISALIGNED_EN
    logic         split_q;
    byte_enable_t be_second_q;
    assign align_err = 1'b0;
`else
    logic unused_be_second;
    assign unused_be_second = ^be_second;
`endif

    // Beat sequencer; all bus outputs are registered here and held while waiting for ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= st_idle;
            bus_en   <= 1'b0;
            bus_addr <= '0;
            bus_data <= '0;
            bus_be   <= '0;
            done     <= 1'b0;
`ifdef STORE_ALIGN_MISALIGNED_EN
            split_q     <= 1'b0;
            be_second_q <= '0;
`else
            align_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifndef STORE_ALIGN_MISALIGNED_EN
            align_err <= 1'b0;
`endif
            case (state)
                st_idle: begin
                    if (req_valid) begin
`ifndef STORE_ALIGN_MISALIGNED_EN
                        if (split) begin
                            align_err <= 1'b1;
                        end else
`endif
                        begin
                            state    <= st_beat1;
                            bus_en   <= 1'b1;
                            bus_addr <= req_addr[31:2];
                            bus_data <= lane_data;
                            bus_be   <= be_first;
`ifdef STORE_ALIGN_MISALIGNED_EN
                            split_q     <= split;
                            be_second_q <= be_second;
`endif
                        end
                    end
                end
                st_beat1: begin
                    if (bus_ack) begin
`ifdef STORE_ALIGN_MISALIGNED_EN
                        if (split_q) begin
                            // Data lanes stay put; only the word address and enables move on.
                            state    <= st_beat2;
                            bus_addr <= bus_addr + 30'd1;
                            bus_be   <= be_second_q;
                        end else
`endif
                        begin
                            state  <= st_idle;
                            bus_en <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end
`ifdef STORE_ALIGN_MISALIGNED_EN
                st_beat2: begin
                    if (bus_ack) begin
                        state  <= st_idle;
                        bus_en <= 1'b0;
                        done   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state  <= st_idle;
                    bus_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_align.sv
// Self-checking bench for store_align: directed cases plus random stores checked
// against a byte-level model of big-endian lane placement.
module tb_store_align;
    import store_align_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    word_t        req_data;
    store_mode_t  req_mode;
    logic         bus_en;
    logic         bus_ack;
    logic [29:0]  bus_addr;
    word_t        bus_data;
    byte_enable_t bus_be;
    logic         done;
    logic         align_err;

    int checks_total  = 0;
    int checks_passed = 0;

    store_align dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .bus_en    (bus_en),
        .bus_ack   (bus_ack),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_be    (bus_be),
        .done      (done),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        assert (got === exp) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Place each stored byte at its own address: byte i of the access (MSB first)
    // goes to address addr+i; lanes past 3 fall into the following word.
    task automatic model(input logic [31:0] addr, input logic [31:0] data, input int mode,
                         output logic [31:0] exp_data, output logic [3:0] be1,
                         output logic [3:0] be2, output logic mis);
        int size;
        int lane;
        logic [7:0] b;
        size     = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
        exp_data = '0;
        be1      = '0;
        be2      = '0;
        for (int i = 0; i < size; i++) begin
            b    = data[8*(size-1-i) +: 8];
            lane = int'(addr[1:0]) + i;
            if (lane < 4) be1[3-lane] = 1'b1;
            else          be2[7-lane] = 1'b1;
            exp_data[8*(3-(lane%4)) +: 8] = b;
        end
        // Lanes not written still carry the replicated pattern.
        for (int l = 0; l < 4; l++) begin
            if (!be1[3-l] && !be2[3-l]) exp_data[8*(3-l) +: 8] = data[8*((size-1-((l-int'(addr[1:0])+8)%size))) +: 8];
        end
        mis = (be2 != 4'b0000);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int mode,
                            input int dly);
        logic [31:0] ed;
        logic [3:0]  be1;
        logic [3:0]  be2;
        logic        mis;
        logic [29:0] wa;
        int          nb;
        model(addr, data, mode, ed, be1, be2, mis);
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        check("done_idle", 32'(done), 32'd0);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_mode  = store_mode_t'(mode);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_mode  = store_mode_t'($urandom_range(0, 2));
`ifndef STORE_ALIGN_MISALIGNED_EN
        if (mis) begin
            @(negedge clk);
            check("mis_bus_en", 32'(bus_en), 32'd0);
            check("mis_align_err", 32'(align_err), 32'd1);
            check("mis_ready", 32'(req_ready), 32'd1);
            check("mis_done", 32'(done), 32'd0);
            @(negedge clk);
            check("mis_err_drop", 32'(align_err), 32'd0);
            check("mis_bus_en2", 32'(bus_en), 32'd0);
            return;
        end
`endif
        nb = mis ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            wa = addr[31:2] + 30'(b);
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                check("beat_en", 32'(bus_en), 32'd1);
                check("beat_addr", 32'(bus_addr), 32'(wa));
                check("beat_data", bus_data, ed);
                check("beat_be", 32'(bus_be), 32'((b == 0) ? be1 : be2));
                check("beat_done", 32'(done), 32'd0);
                check("beat_err", 32'(align_err), 32'd0);
                check("beat_ready", 32'(req_ready), 32'd0);
                bus_ack   = (k == dly);
                req_valid = (k == dly) ? 1'b0 : 1'($urandom % 2);
            end
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        req_valid = 1'b0;
        check("end_done", 32'(done), 32'd1);
        check("end_bus_en", 32'(bus_en), 32'd0);
        check("end_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_mode  = store_byte;
        bus_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(align_err), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_data", bus_data, 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;

        // Directed cases from the store walk-through.
        do_store(32'h0000_0102, 32'h0000_00A5, 0, 0);
        check("byte_data_const", bus_data, 32'hA5A5A5A5);
        do_store(32'h0000_0201, 32'h0000_1234, 1, 1);
        check("half_data_const", bus_data, 32'h34123412);
        check("half_be_const", 32'(bus_be), 32'h6);
        do_store(32'h0000_0003, 32'h1122_3344, 2, 0);
        do_store(32'h0000_0000, 32'h1122_3344, 2, 5);
        check("word_data_const", bus_data, 32'h11223344);
        do_store(32'hFFFF_FFFE, 32'hDEAD_BEEF, 1, 2);
        do_store(32'hFFFF_FFFF, 32'hCAFE_F00D, 1, 1);

        // Reset while a beat is outstanding.
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = store_word;
        req_data  = 32'h1122_3344;
`ifdef STORE_ALIGN_MISALIGNED_EN
        req_addr = 32'h0000_0003;
`else
        req_addr = 32'h0000_0000;
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_en_before", 32'(bus_en), 32'd1);
`ifdef STORE_ALIGN_MISALIGNED_EN
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rstmid_beat2_be", 32'(bus_be), 32'hE);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_en", 32'(bus_en), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_be", 32'(bus_be), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_store(32'h0000_0040, 32'h5566_7788, 2, 1);

        // Random stores with random ack latency.
        for (int n = 0; n < 60; n++) begin
            do_store($urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/store_align.md
# store_align

Store-path counterpart of the load byte aligner: accepts a register word, store mode and byte address from the pipeline, and drives big-endian lane-aligned write data plus byte enables onto the data-memory bus. Misaligned halfword and word stores are split into two word-bus beats, or rejected when splitting is compiled out. Sits between the load/store stage and the data-memory port.

## Interface
- No parameters; widths come from `Pu_types::Word` (32 bit).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: store request present.
- `req_ready` out 1: unit idle, request can be accepted.
- `req_addr` in 32: byte address.
- `req_data` in Word: store data, right-aligned for byte and halfword.
- `req_mode` in Store_mode: Store_byte / Store_halfword / Store_word.
- `bus_en` out 1: write beat valid.
- `bus_ack` in 1: beat accepted.
- `bus_addr` out 30: word address.
- `bus_data` out Word: lane-aligned data.
- `bus_be` out 4: byte enables; bit 3 = bits 31:24.
- `done` out 1: one-cycle pulse, store complete.
- `align_err` out 1: one-cycle pulse, misaligned store rejected (macro off only).

## Operation
- Big-endian lanes: bsel = `req_addr[1:0]`; bsel 00 selects bits 31:24.
- Replicate data by mode: byte into all 4 lanes; halfword h as {h,h}; word unchanged.
- `bus_data` = replicated word rotated right by 8·bsel; identical on both beats of a split.
- Byte enables, first beat: byte 1000>>bsel; halfword 1100>>bsel (bsel 11 gives 0001); word 1111>>bsel.
- Split needed when halfword bsel=11 or word bsel≠00. Second beat: `bus_addr`+1 (wraps modulo 2^30, no flag); enables = complement of first-beat enables within the access (halfword 1000; word 1111<<(4−bsel)).
- FSM: IDLE → BEAT1 on accept; BEAT1 → IDLE on `bus_ack` if no split, else → BEAT2; BEAT2 → IDLE on `bus_ack`.
- `req_ready` = (state == IDLE). Request inputs sampled only at accept and held internally.

## Timing
- Reset values: `bus_en`, `done`, `align_err` = 0; `bus_addr`, `bus_data`, `bus_be` = 0; `req_ready` = 1; state IDLE.
- All outputs registered except `req_ready`.
- `bus_en` rises the cycle after accept; address, data and enables are stable while `bus_en`=1 and `bus_ack`=0.
- `bus_ack` sampled only while `bus_en`=1; `bus_ack` in the same cycle `bus_en` rises completes that beat.
- Second beat follows immediately: `bus_en` stays high, with address and enables updated, the cycle after the first ack.
- `done` pulses the cycle after the final ack; `req_ready` is high in that same cycle. Minimum 2 cycles per aligned store, 3 per split store.
- Reset mid-operation: `bus_en` drops immediately. A completed first beat is not undone.

## Configuration
- `STORE_ALIGN_MISALIGNED_EN` defined: misaligned stores split as above; `align_err` tied 0.
- Not defined: a misaligned request is accepted, issues no bus beat, and pulses `align_err` the cycle after accept; `done` stays 0. BEAT2 is absent.

## Structure
- `Pu_types`: add `Store_mode` enum (Store_byte, Store_halfword, Store_word) and a `Byte_enable` 4-bit typedef.
- Sub-module `Store_lane_gen`: combinational replicate/rotate plus first/second-beat enable generation. FSM and registers stay in the top.

## Test plan
- Byte 0xA5 at addr 0x102 -> one beat: `bus_addr`=0x40, `bus_data`=0xA5A5A5A5, `bus_be`=0010; `done` 1 cycle after ack.
- Halfword 0x1234 at 0x201 -> `bus_data`=0x34123412, `bus_be`=0110.
- Word 0x11223344 at 0x3 (macro on) -> beat 1: addr 0x0, data 0x22334411, be 0001; beat 2: addr 0x1, same data, be 1110.
- Same word request with macro off -> no `bus_en`; `align_err` pulses once; `req_ready` returns high next cycle.
- `bus_ack` held low 5 cycles on aligned word at 0x0 -> `bus_en`, `bus_data`=0x11223344, `bus_be`=1111 stable throughout; `done` only after ack.
- `reset` asserted while BEAT2 is pending -> `bus_en`=0 at once; after release, `req_ready`=1 and a new request works.
